// File: rtl/prog_seq_pkg.sv
// Shared opcode, register-code, reg_en index and source_sel constants for the program sequencer.
// Pure declarations: no latency, no flow control.
package prog_seq_pkg;

    localparam logic [1:0] OP_MOV  = 2'b10;
    localparam logic [2:0] OP_ALU  = 3'b110;
    localparam logic [3:0] OP_JMP  = 4'b1110;
    localparam logic [3:0] OP_JNZ  = 4'b1111;
    localparam logic [7:0] OP_HALT = 8'hBF;

    localparam logic [2:0] REG_OREG = 3'd4;
    localparam logic [2:0] REG_I    = 3'd6;
    localparam logic [2:0] REG_DM   = 3'd7;

    localparam int EN_R    = 4;
    localparam int EN_I    = 6;
    localparam int EN_OREG = 8;

    localparam logic [3:0] SRC_PM   = 4'd8;
    localparam logic [3:0] SRC_PINS = 4'd9;
    localparam logic [3:0] SRC_ZERO = 4'd10;

    localparam logic [3:0] NOP_NIBBLE = 4'h8;

    typedef enum logic [1:0] {
        S_RESET,
        S_RUN,
        S_FLUSH,
        S_HALT
    } state_t;

    // Destination code 4 is o_reg, which lives at the top of the reg_en map.
    function automatic logic [8:0] dst_enable(input logic [2:0] dst);
        logic [8:0] en;
        if (dst == REG_OREG) en = 9'd1 << EN_OREG;
        else                 en = 9'd1 << dst;
        return en;
    endfunction

endpackage

// File: rtl/program_sequencer_instr_decoder.sv
// instr_decoder: combinational decode of ir into the computational-unit control bundle, jump flag and target.
// Zero latency, no flow control; PROG_SEQ_HALT_EN turns 8'hBF into HALT.
module instr_decoder
    import prog_seq_pkg::*;
(
    input  logic [7:0] ir_i,
    input  logic       ir_valid_i,
    input  logic       r_eq_0_i,
    output logic [3:0] source_sel_o,
    output logic [8:0] reg_en_o,
    output logic       i_sel_o,
    output logic       x_sel_o,
    output logic       y_sel_o,
    output logic [3:0] nibble_ir_o,
    output logic       jump_o,
    output logic [3:0] target_o,
    output logic       halt_o
);

    logic [2:0] dst;
    logic [2:0] src;
    logic       pins;
    logic       dm_access;

    always_comb begin
        source_sel_o = SRC_ZERO;
        reg_en_o     = '0;
        i_sel_o      = 1'b0;
        x_sel_o      = 1'b0;
        y_sel_o      = 1'b0;
        nibble_ir_o  = NOP_NIBBLE;
        jump_o       = 1'b0;
        halt_o       = 1'b0;
        dst          = ir_i[6:4];
        src          = ir_i[2:0];
        pins         = 1'b0;
        dm_access    = 1'b0;
        if (ir_valid_i) begin
`ifdef PROG_SEQ_HALT_EN
            if (ir_i == OP_HALT) halt_o = 1'b1;
            else
`endif
            if (ir_i[7] == 1'b0) begin
                source_sel_o = SRC_PM;
                nibble_ir_o  = ir_i[3:0];
                reg_en_o     = dst_enable(dst);
                dm_access    = (dst == REG_DM);
            end else if (ir_i[7:6] == OP_MOV) begin
                dst          = ir_i[5:3];
                pins         = (dst == src);
                source_sel_o = pins ? SRC_PINS : {1'b0, src};
                reg_en_o     = dst_enable(dst);
                dm_access    = (dst == REG_DM) || (src == REG_DM && !pins);
            end else if (ir_i[7:5] == OP_ALU) begin
                x_sel_o        = ir_i[4];
                y_sel_o        = ir_i[3];
                nibble_ir_o    = {1'b0, ir_i[2:0]};
                reg_en_o[EN_R] = 1'b1;
            end else if (ir_i[7:4] == OP_JMP) begin
                jump_o = 1'b1;
            end else if (ir_i[7:4] == OP_JNZ) begin
                jump_o = !r_eq_0_i;
            end
            // A dm access post-increments i unless i itself is the bus destination.
            if (dm_access && dst != REG_I) begin
                reg_en_o[EN_I] = 1'b1;
                i_sel_o        = 1'b1;
            end
        end
    end

    assign target_o = ir_i[3:0];

endmodule

// File: rtl/program_sequencer.sv
// program_sequencer: pc, instruction register and RESET/RUN/FLUSH(/HALT) FSM; one fetch per cycle, taken jump costs 2.
// No backpressure; PROG_SEQ_HALT_EN enables the sticky HALT state.
module program_sequencer
    import prog_seq_pkg::*;
#(
    parameter int PM_ADDR_W = 8
) (
    input  logic                 clk,
    input  logic                 sync_reset_n,
    input  logic [7:0]           pm_data,
    input  logic                 r_eq_0,
    output logic [PM_ADDR_W-1:0] pm_addr,
    output logic [PM_ADDR_W-1:0] ir_pc,
    output logic [7:0]           ir,
    output logic [3:0]           nibble_ir,
    output logic                 i_sel,
    output logic                 x_sel,
    output logic                 y_sel,
    output logic [3:0]           source_sel,
    output logic [8:0]           reg_en,
    output logic                 halted
);

    localparam logic [PM_ADDR_W-1:0] PC_INC = {{(PM_ADDR_W-1){1'b0}}, 1'b1};

    state_t                 state_q, state_d;
    logic [PM_ADDR_W-1:0]   pc_q, pc_d;
    logic [PM_ADDR_W-1:0]   ir_pc_q, ir_pc_d;
    logic [7:0]             ir_q, ir_d;
    logic                   ir_valid_q, ir_valid_d;
    logic                   jump_dec;
    logic                   halt_dec;
    logic [3:0]             jump_tgt;

    instr_decoder u_dec (
        .ir_i         (ir_q),
        .ir_valid_i   (ir_valid_q),
        .r_eq_0_i     (r_eq_0),
        .source_sel_o (source_sel),
        .reg_en_o     (reg_en),
        .i_sel_o      (i_sel),
        .x_sel_o      (x_sel),
        .y_sel_o      (y_sel),
        .nibble_ir_o  (nibble_ir),
        .jump_o       (jump_dec),
        .target_o     (jump_tgt),
        .halt_o       (halt_dec)
    );

    always_ff @(posedge clk) begin
        if (!sync_reset_n) state_q <= S_RESET;
        else               state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET: state_d = S_RUN;
            S_RUN: begin
                if (jump_dec)      state_d = S_FLUSH;
                else if (halt_dec) state_d = S_HALT;
            end
            S_FLUSH: state_d = S_RUN;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_RESET;
        endcase
    end

    always_comb begin
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        case (state_q)
            S_RUN: begin
                if (jump_dec) begin
                    // Page comes from the jump's own address; pc may already sit on the next page.
                    pc_d       = {ir_pc_q[PM_ADDR_W-1:4], jump_tgt};
                    ir_valid_d = 1'b0;
                end else if (halt_dec) begin
                    ir_valid_d = 1'b0;
                end else begin
                    ir_d       = pm_data;
                    ir_pc_d    = pc_q;
                    pc_d       = pc_q + PC_INC;
                    ir_valid_d = 1'b1;
                end
            end
            S_RESET, S_FLUSH: begin
                ir_d       = pm_data;
                ir_pc_d    = pc_q;
                pc_d       = pc_q + PC_INC;
                ir_valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!sync_reset_n) begin
            pc_q       <= '0;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    assign pm_addr = pc_q;
    assign ir_pc   = ir_pc_q;
    assign ir      = ir_q;

`ifdef PROG_SEQ_HALT_EN
    assign halted = (state_q == S_HALT);
`else
    assign halted = 1'b0;
`endif

endmodule
